// File: rtl/nand_dq_wr_burst.sv
// nand_dq_wr_burst
// Write-direction sequencer for the NAND DDR data bus (clk0 domain). Takes a
// burst command plus a stream of {fall, rise} byte pairs and drives the DQ
// IOB data, DQ/DQS tri-state enables and the DQS running enable. DQS is
// driven low for a programmable preamble and postamble.
//
// Build option: define NAND_DQ_WR_STALL_CNT_EN to add the stall_cnt output
// (saturating count of data stall cycles in the current burst).
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | bus released, cmd_ready high
// PRE   | DQS driven low; word accepted in the final preamble cycle
// DATA  | accepting words while remaining != 0
// POST  | last word on the bus, then DQS driven low for the postamble
module nand_dq_wr_burst #(
    parameter int DQ_WIDTH    = 8,
    parameter int LEN_WIDTH   = 16,
    parameter int PRE_CYCLES  = 1,
    parameter int POST_CYCLES = 1
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [2*DQ_WIDTH-1:0] wdata,
    output logic [DQ_WIDTH-1:0]   wr_data_rise,
    output logic [DQ_WIDTH-1:0]   wr_data_fall,
    output logic                  dq_oe_n,
    output logic                  dqs_oe_n,
    output logic                  dqs_toggle,
    output logic                  busy,
`ifdef NAND_DQ_WR_STALL_CNT_EN
    output logic                  done,
    output logic [15:0]           stall_cnt
`else
    output logic                  done
`endif
);

    typedef enum logic [1:0] {IDLE, PRE, DATA, POST} state_t;

    localparam logic [3:0]           PRE_LOAD  = 4'(PRE_CYCLES - 1);
    localparam logic [3:0]           POST_LOAD = 4'(POST_CYCLES);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE   = LEN_WIDTH'(1);

    state_t               state, state_nxt;
    logic [LEN_WIDTH-1:0] remaining, rem_nxt;
    logic [3:0]           phase_cnt, phase_nxt;

    logic [DQ_WIDTH-1:0]  rise_nxt, fall_nxt;
    logic                 dq_oe_n_nxt, dqs_oe_n_nxt, toggle_nxt, done_nxt;
    logic                 cmd_fire, accept;

    // Handshakes decode registered state only (no input-to-output path).
    assign cmd_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign wdata_ready = ((state == PRE) && (phase_cnt == '0)) ||
                         ((state == DATA) && (remaining != '0));
    assign cmd_fire    = cmd_valid & cmd_ready;
    assign accept      = wdata_valid & wdata_ready;

    // State, remaining-word and phase counter registers.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            state     <= IDLE;
            remaining <= '0;
            phase_cnt <= '0;
        end else begin
            state     <= state_nxt;
            remaining <= rem_nxt;
            phase_cnt <= phase_nxt;
        end
    end

    // Next-state and counter update; the last-word accept overrides to POST.
    always_comb begin
        state_nxt = state;
        rem_nxt   = remaining;
        phase_nxt = phase_cnt;
        case (state)
            IDLE: begin
                if (cmd_fire) begin
                    rem_nxt = cmd_len;
                    if (cmd_len != '0) begin
                        state_nxt = PRE;
                        phase_nxt = PRE_LOAD;
                    end
                end
            end
            PRE: begin
                if (phase_cnt != '0) phase_nxt = phase_cnt - 1'b1;
                else                 state_nxt = DATA;
            end
            POST: begin
                if (phase_cnt != '0) phase_nxt = phase_cnt - 1'b1;
                else                 state_nxt = IDLE;
            end
            default: ;
        endcase
        if (accept) begin
            rem_nxt = remaining - 1'b1;
            if (remaining == LEN_ONE) begin
                state_nxt = POST;
                phase_nxt = POST_LOAD;
            end
        end
    end

    // Next values of the registered bus outputs; data holds unless a word is taken.
    always_comb begin
        rise_nxt     = wr_data_rise;
        fall_nxt     = wr_data_fall;
        dq_oe_n_nxt  = dq_oe_n;
        dqs_oe_n_nxt = dqs_oe_n;
        toggle_nxt   = 1'b0;
        done_nxt     = 1'b0;
        if (wdata_ready) begin
            dq_oe_n_nxt = 1'b0;
            toggle_nxt  = wdata_valid;
            if (wdata_valid) begin
                rise_nxt = wdata[DQ_WIDTH-1:0];
                fall_nxt = wdata[2*DQ_WIDTH-1:DQ_WIDTH];
            end
        end
        case (state)
            IDLE: begin
                if (cmd_fire) begin
                    if (cmd_len == '0) done_nxt     = 1'b1;
                    else               dqs_oe_n_nxt = 1'b0;
                end
            end
            POST: begin
                dq_oe_n_nxt = 1'b1;
                if (phase_cnt == '0) begin
                    dqs_oe_n_nxt = 1'b1;
                    done_nxt     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            wr_data_rise <= '0;
            wr_data_fall <= '0;
            dq_oe_n      <= 1'b1;
            dqs_oe_n     <= 1'b1;
            dqs_toggle   <= 1'b0;
            done         <= 1'b0;
        end else begin
            wr_data_rise <= rise_nxt;
            wr_data_fall <= fall_nxt;
            dq_oe_n      <= dq_oe_n_nxt;
            dqs_oe_n     <= dqs_oe_n_nxt;
            dqs_toggle   <= toggle_nxt;
            done         <= done_nxt;
        end
    end

`ifdef NAND_DQ_WR_STALL_CNT_EN
    // Saturating stall counter, cleared on command accept, held after done.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0)                                                 stall_cnt <= '0;
        else if (cmd_fire)                                        stall_cnt <= '0;
        else if (wdata_ready && !wdata_valid && stall_cnt != '1)  stall_cnt <= stall_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_nand_dq_wr_burst.sv
// tb_nand_dq_wr_burst
// Two DUT instances (PRE=1/POST=1 and PRE=3/POST=2) share one stimulus set;
// sel picks which one receives commands and is observed. Expected traces are
// built per burst from the burst rules: preamble, one ready slot per word
// attempt, last-word cycle, postamble, done cycle.
module tb_nand_dq_wr_burst;

    localparam int DW = 8;
    localparam int LW = 16;

    typedef struct packed {
        logic [22:0] exp;
        logic        v;
        logic [15:0] w;
    } entry_t;

    logic          clk0 = 1'b0;
    logic          rst0;
    logic          cmd_valid;
    logic [LW-1:0] cmd_len;
    logic          wdata_valid;
    logic [15:0]   wdata;
    logic          sel;

    logic          cmd_ready_a, wdata_ready_a, dq_oe_n_a, dqs_oe_n_a, dqs_toggle_a, busy_a, done_a;
    logic          cmd_ready_b, wdata_ready_b, dq_oe_n_b, dqs_oe_n_b, dqs_toggle_b, busy_b, done_b;
    logic [DW-1:0] rise_a, fall_a, rise_b, fall_b;
    logic [22:0]   obs;

    int checks = 0;
    int errors = 0;
    int cnt_dqs_low, cnt_toggle, cnt_ready;
    logic [7:0]  last_r [2];
    logic [7:0]  last_f [2];
    logic [15:0] wq[$];

    always #5 clk0 = ~clk0;

`ifdef NAND_DQ_WR_STALL_CNT_EN
    logic [15:0] stall_a, stall_b, obs_stall;
    assign obs_stall = sel ? stall_b : stall_a;
`endif

    nand_dq_wr_burst #(.DQ_WIDTH(DW), .LEN_WIDTH(LW), .PRE_CYCLES(1), .POST_CYCLES(1)) u_dut_a (
        .clk0(clk0), .rst0(rst0),
        .cmd_valid(cmd_valid & ~sel), .cmd_ready(cmd_ready_a), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready_a), .wdata(wdata),
        .wr_data_rise(rise_a), .wr_data_fall(fall_a),
        .dq_oe_n(dq_oe_n_a), .dqs_oe_n(dqs_oe_n_a), .dqs_toggle(dqs_toggle_a),
        .busy(busy_a),
`ifdef NAND_DQ_WR_STALL_CNT_EN
        .done(done_a), .stall_cnt(stall_a)
`else
        .done(done_a)
`endif
    );

    nand_dq_wr_burst #(.DQ_WIDTH(DW), .LEN_WIDTH(LW), .PRE_CYCLES(3), .POST_CYCLES(2)) u_dut_b (
        .clk0(clk0), .rst0(rst0),
        .cmd_valid(cmd_valid & sel), .cmd_ready(cmd_ready_b), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready_b), .wdata(wdata),
        .wr_data_rise(rise_b), .wr_data_fall(fall_b),
        .dq_oe_n(dq_oe_n_b), .dqs_oe_n(dqs_oe_n_b), .dqs_toggle(dqs_toggle_b),
        .busy(busy_b),
`ifdef NAND_DQ_WR_STALL_CNT_EN
        .done(done_b), .stall_cnt(stall_b)
`else
        .done(done_b)
`endif
    );

    // bit 22 cmd_ready, 21 wdata_ready, 20 busy, 19 done, 18 dqs_oe_n,
    // 17 dq_oe_n, 16 dqs_toggle, 15:8 rise, 7:0 fall
    assign obs = sel ?
        {cmd_ready_b, wdata_ready_b, busy_b, done_b, dqs_oe_n_b, dq_oe_n_b, dqs_toggle_b, rise_b, fall_b} :
        {cmd_ready_a, wdata_ready_a, busy_a, done_a, dqs_oe_n_a, dq_oe_n_a, dqs_toggle_a, rise_a, fall_a};

    function automatic logic [22:0] mk(input logic cr, input logic rdy, input logic bsy,
                                       input logic dn, input logic dqso, input logic dqo,
                                       input logic tg, input logic [7:0] r, input logic [7:0] f);
        return {cr, rdy, bsy, dn, dqso, dqo, tg, r, f};
    endfunction

    task automatic check_bus(input string tag, input logic [22:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // vmode: 0 random valid, 1 always valid, 2 valid from vpat (bit per ready slot).
    task automatic run_burst(input int len, input int vmode, input logic [31:0] vpat,
                             input bit hold_cmd, input int abort_at, input string tag);
        entry_t     tr[$];
        entry_t     e;
        int         pre_c  = sel ? 3 : 1;
        int         post_c = sel ? 2 : 1;
        int         idx    = sel ? 1 : 0;
        logic [7:0] r = last_r[idx];
        logic [7:0] f = last_f[idx];
        logic       tg = 1'b0, dqo = 1'b1;
        int         rem = len, slot = 0, stalls = 0;
        logic       v;
        logic [15:0] w;

        if (len > 0) begin
            for (int i = 0; i < pre_c - 1; i++) begin
                e.exp = mk(0, 0, 1, 0, 0, 1, 0, r, f); e.v = 1'($urandom); e.w = 16'($urandom);
                tr.push_back(e);
            end
            while (rem > 0) begin
                v = (vmode == 0) ? ($urandom_range(3) != 0) : (vmode == 1) ? 1'b1 : vpat[slot];
                slot++;
                w = v ? ((wq.size() > 0) ? wq.pop_front() : 16'($urandom)) : 16'($urandom);
                e.exp = mk(0, 1, 1, 0, 0, dqo, tg, r, f); e.v = v; e.w = w;
                tr.push_back(e);
                dqo = 1'b0;
                if (v) begin
                    r = w[7:0]; f = w[15:8]; tg = 1'b1; rem--;
                end else begin
                    tg = 1'b0; stalls++;
                end
            end
            e.exp = mk(0, 0, 1, 0, 0, dqo, tg, r, f); e.v = 1'($urandom); e.w = 16'($urandom);
            tr.push_back(e);
            for (int i = 0; i < post_c; i++) begin
                e.exp = mk(0, 0, 1, 0, 0, 1, 0, r, f); e.v = 1'($urandom); e.w = 16'($urandom);
                tr.push_back(e);
            end
        end
        e.exp = mk(1, 0, 0, 1, 1, 1, 0, r, f); e.v = 1'($urandom); e.w = 16'($urandom);
        tr.push_back(e);

        cmd_valid   = 1'b1;
        cmd_len     = LW'(len);
        wdata_valid = 1'($urandom);
        wdata       = 16'($urandom);
        for (int k = 0; k < tr.size(); k++) begin
            @(posedge clk0);
            @(negedge clk0);
            if (!hold_cmd) cmd_valid = 1'b0;
            wdata_valid = tr[k].v;
            wdata       = tr[k].w;
            check_bus(tag, tr[k].exp);
            if (obs[18] == 1'b0) cnt_dqs_low++;
            if (obs[16] == 1'b1) cnt_toggle++;
            if (obs[21] == 1'b1) cnt_ready++;
            if (k == abort_at) return;
        end
`ifdef NAND_DQ_WR_STALL_CNT_EN
        check_int({tag, "_stall_cnt"}, int'(obs_stall), stalls);
`endif
        last_r[idx] = r;
        last_f[idx] = f;
    endtask

    task automatic idle_cycles(input int n, input string tag);
        int idx = sel ? 1 : 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk0);
            @(negedge clk0);
            cmd_valid   = 1'b0;
            wdata_valid = 1'($urandom);
            wdata       = 16'($urandom);
            check_bus(tag, mk(1, 0, 0, 0, 1, 1, 0, last_r[idx], last_f[idx]));
        end
    endtask

    task automatic clear_counts();
        cnt_dqs_low = 0;
        cnt_toggle  = 0;
        cnt_ready   = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst0 = 1'b1; cmd_valid = 1'b0; cmd_len = '0; wdata_valid = 1'b0; wdata = '0; sel = 1'b0;
        last_r[0] = '0; last_f[0] = '0; last_r[1] = '0; last_f[1] = '0;
        repeat (3) @(negedge clk0);
        rst0 = 1'b0;
        check_bus("reset_a", mk(1, 0, 0, 0, 1, 1, 0, 8'h00, 8'h00));
        idle_cycles(2, "idle_a");

        // Basic burst with fixed words, always valid.
        wq = '{16'h1100, 16'h3322, 16'h5544, 16'h7766};
        clear_counts();
        run_burst(4, 1, 32'h0, 1'b0, -1, "basic");
        check_int("basic_dqs_low_cycles", cnt_dqs_low, 6);
        check_int("basic_toggle_cycles", cnt_toggle, 4);

        // Two stall cycles after word 2.
        wq = '{16'h1100, 16'h3322, 16'h5544, 16'h7766};
        clear_counts();
        run_burst(4, 2, 32'b110011, 1'b0, -1, "stall");
        check_int("stall_toggle_cycles", cnt_toggle, 4);

        // Zero-length command.
        clear_counts();
        run_burst(0, 0, 32'h0, 1'b0, -1, "len0");
        check_int("len0_dqs_low_cycles", cnt_dqs_low, 0);
        idle_cycles(1, "len0_after");

        // Long preamble/postamble instance.
        sel = 1'b1;
        idle_cycles(1, "idle_b");
        clear_counts();
        run_burst(1, 1, 32'h0, 1'b0, -1, "pre3");
        check_int("pre3_ready_cycles", cnt_ready, 1);
        check_int("pre3_dqs_low_cycles", cnt_dqs_low, 6);
        for (int i = 0; i < 4; i++)
            run_burst($urandom_range(1, 6), 0, 32'h0, 1'b0, -1, "rand_b");
        idle_cycles(1, "idle_b2");

        // Back-to-back on the short instance, command held through the first burst.
        sel = 1'b0;
        idle_cycles(1, "idle_a2");
        clear_counts();
        run_burst(3, 1, 32'h0, 1'b1, -1, "b2b_first");
        run_burst(2, 1, 32'h0, 1'b0, -1, "b2b_second");
        check_int("b2b_toggle_cycles", cnt_toggle, 5);
        for (int i = 0; i < 8; i++)
            run_burst($urandom_range(0, 7), 0, 32'h0, (i < 7) ? 1'($urandom) : 1'b0, -1, "rand_a");
        idle_cycles(1, "idle_a3");

        // Reset in the middle of DATA, after word 2 of 4.
        run_burst(4, 1, 32'h0, 1'b0, 2, "abort");
        #2 rst0 = 1'b1;
        #1;
        last_r[0] = '0;
        last_f[0] = '0;
        check_bus("async_reset", mk(1, 0, 0, 0, 1, 1, 0, 8'h00, 8'h00));
`ifdef NAND_DQ_WR_STALL_CNT_EN
        check_int("reset_stall_cnt", int'(obs_stall), 0);
`endif
        @(negedge clk0);
        @(negedge clk0);
        rst0 = 1'b0;
        idle_cycles(3, "post_reset_idle");
        run_burst(2, 0, 32'h0, 1'b0, -1, "after_reset");
        idle_cycles(1, "final_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
